// File: rtl/bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// bus_arbiter_rr
//
// Purpose: arbitrates NUM_MASTERS memory masters onto one slave bus. A
// request is registered into a grant that is held until the slave completes
// the access or the master withdraws its request. The arbitration policy is
// round-robin (ROUND_ROBIN=1) or fixed priority, lowest index first
// (ROUND_ROBIN=0).
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   m_address_in        per-master address     (slice i = master i)
//   m_read_in           per-master read request
//   m_write_in          per-master write request
//   m_write_mask_in     per-master byte mask
//   m_write_value_in    per-master write data
//   m_read_value_out    per-master read data (granted slice only, others 0)
//   m_ready_out         one-hot completion pulse to the granted master
//   address_out, read_out, write_out, write_mask_out, write_value_out
//                       slave request, driven only while BUSY
//   read_value_in       slave read data
//   slave_ready_in      slave completes the current access this cycle
//   grant_valid_out     high while BUSY; this is the FSM state
//   grant_index_out     owning master (0 when idle)
//
// Handshake: a master raises read and/or write and holds request, address,
// mask and data stable until it sees its m_ready_out bit. The transfer
// completes in the BUSY cycle where the request is still up and
// slave_ready_in=1; m_ready_out and the read data are valid in that same
// cycle. Dropping the request while granted aborts the transfer with no
// ready pulse. Every transfer is followed by one IDLE cycle.
// ---------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 1,
  localparam int MASK_W = DATA_WIDTH / 8,
  localparam int GW     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address_in,
  input  logic [NUM_MASTERS-1:0]            m_read_in,
  input  logic [NUM_MASTERS-1:0]            m_write_in,
  input  logic [NUM_MASTERS*MASK_W-1:0]     m_write_mask_in,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_write_value_in,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_read_value_out,
  output logic [NUM_MASTERS-1:0]            m_ready_out,
  output logic [ADDR_WIDTH-1:0]             address_out,
  output logic                              read_out,
  output logic                              write_out,
  output logic [MASK_W-1:0]                 write_mask_out,
  output logic [DATA_WIDTH-1:0]             write_value_out,
  input  logic [DATA_WIDTH-1:0]             read_value_in,
  input  logic                              slave_ready_in,
  output logic                              grant_valid_out,
  output logic [GW-1:0]                     grant_index_out
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;

  logic [NUM_MASTERS-1:0] req;
  logic [GW-1:0]          winner;
  logic [GW-1:0]          win_hi, win_lo, win_any;
  logic                   found_hi;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic                   sel_rd, sel_wr, sel_req;
  logic [MASK_W-1:0]      sel_mask;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Per-master outputs are decoded from these two flags.
  logic                   ready_hit;
  logic                   drive_rdata;

  assign req = m_read_in | m_write_in;

  // Winner selection. The loop runs from high to low index so the last
  // assignment is the lowest matching index. win_hi is the lowest requester
  // above last_q; if there is none the search wraps to win_lo, the lowest
  // requester at or below last_q. win_any is the plain fixed-priority pick.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    win_any  = '0;
    found_hi = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_any = GW'(i);
        if (GW'(i) > last_q) begin
          win_hi   = GW'(i);
          found_hi = 1'b1;
        end else begin
          win_lo = GW'(i);
        end
      end
    end
    if (ROUND_ROBIN != 0) begin
      winner = found_hi ? win_hi : win_lo;
    end else begin
      winner = win_any;
    end
  end

  // Mux of the granted master's current request fields.
  always_comb begin
    sel_addr = '0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    sel_req  = 1'b0;
    sel_mask = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GW'(i)) begin
        sel_addr = m_address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_rd   = m_read_in[i];
        sel_wr   = m_write_in[i];
        sel_req  = req[i];
        sel_mask = m_write_mask_in[i*MASK_W +: MASK_W];
        sel_data = m_write_value_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM next state and slave-side outputs.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    address_out     = '0;
    read_out        = 1'b0;
    write_out       = 1'b0;
    write_mask_out  = '0;
    write_value_out = '0;
    grant_valid_out = 1'b0;
    grant_index_out = '0;
    ready_hit       = 1'b0;
    drive_rdata     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // slave_ready_in has no meaning here and is not looked at.
        if (|req) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        grant_valid_out = 1'b1;
        grant_index_out = grant_q;
        if (sel_req) begin
          address_out     = sel_addr;
          read_out        = sel_rd;
          write_out       = sel_wr;
          write_mask_out  = sel_mask;
          write_value_out = sel_data;
          drive_rdata     = 1'b1;
          if (slave_ready_in) begin
            ready_hit = 1'b1;
            state_d   = IDLE;
            last_d    = grant_q;
          end
        end else begin
          // Abort: the owner withdrew, so strobes stay low and any
          // slave_ready_in this cycle is discarded.
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Master-side outputs: only the granted slice is ever non-zero.
  always_comb begin
    m_read_value_out = '0;
    m_ready_out      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GW'(i)) begin
        m_ready_out[i] = ready_hit;
        if (drive_rdata) begin
          m_read_value_out[i*DATA_WIDTH +: DATA_WIDTH] = read_value_in;
        end
      end
    end
  end

  // last_q resets to the top index so the first round-robin search starts
  // at master 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Two 4-master arbiters share the same stimulus: one round-robin, one fixed
// priority. Directed vectors with hand-computed expected values cover reset
// and idle, a zero-wait read, a write with wait states, round-robin
// fairness versus fixed priority, abort, and reset in the middle of a grant.
// ---------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared master / slave stimulus
  logic [N*AW-1:0] m_address;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N*MW-1:0] m_mask;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   read_value;
  logic            slave_ready;

  // round-robin instance outputs
  logic [N*DW-1:0] rr_rdata;
  logic [N-1:0]    rr_ready;
  logic [AW-1:0]   rr_addr;
  logic            rr_rd, rr_wr, rr_gv;
  logic [MW-1:0]   rr_mask;
  logic [DW-1:0]   rr_wdata;
  logic [1:0]      rr_gi;

  // fixed-priority instance outputs
  logic [N*DW-1:0] fp_rdata;
  logic [N-1:0]    fp_ready;
  logic [AW-1:0]   fp_addr;
  logic            fp_rd, fp_wr, fp_gv;
  logic [MW-1:0]   fp_mask;
  logic [DW-1:0]   fp_wdata;
  logic [1:0]      fp_gi;

  bus_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1)
  ) dut_rr (
    .clk(clk), .reset(reset),
    .m_address_in(m_address), .m_read_in(m_read), .m_write_in(m_write),
    .m_write_mask_in(m_mask), .m_write_value_in(m_wdata),
    .m_read_value_out(rr_rdata), .m_ready_out(rr_ready),
    .address_out(rr_addr), .read_out(rr_rd), .write_out(rr_wr),
    .write_mask_out(rr_mask), .write_value_out(rr_wdata),
    .read_value_in(read_value), .slave_ready_in(slave_ready),
    .grant_valid_out(rr_gv), .grant_index_out(rr_gi)
  );

  bus_arbiter_rr #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0)
  ) dut_fp (
    .clk(clk), .reset(reset),
    .m_address_in(m_address), .m_read_in(m_read), .m_write_in(m_write),
    .m_write_mask_in(m_mask), .m_write_value_in(m_wdata),
    .m_read_value_out(fp_rdata), .m_ready_out(fp_ready),
    .address_out(fp_addr), .read_out(fp_rd), .write_out(fp_wr),
    .write_mask_out(fp_mask), .write_value_out(fp_wdata),
    .read_value_in(read_value), .slave_ready_in(slave_ready),
    .grant_valid_out(fp_gv), .grant_index_out(fp_gi)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  int         exp_rr[5];
  logic [3:0] oh;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_master(input int i, input logic rd, input logic wr,
                            input logic [AW-1:0] addr,
                            input logic [MW-1:0] mask,
                            input logic [DW-1:0] data);
    m_read[i]              = rd;
    m_write[i]             = wr;
    m_address[i*AW +: AW]  = addr;
    m_mask[i*MW +: MW]     = mask;
    m_wdata[i*DW +: DW]    = data;
  endtask

  task automatic clear_all();
    m_read    = '0;
    m_write   = '0;
    m_address = '0;
    m_mask    = '0;
    m_wdata   = '0;
  endtask

  // watchdog: the stimulus is fixed-length, this only guards a hung sim
  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    slave_ready = 1'b0;
    read_value  = '0;
    clear_all();

    // reset then idle, with stray slave_ready pulses that must be ignored
    cycle();
    cycle();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      slave_ready = (c % 3 == 0);
      cycle();
      settle();
      check("idle_gv_rr", 64'(rr_gv), 64'd0);
      check("idle_bus_rr", 64'({rr_addr, rr_rd, rr_wr, rr_ready, rr_gi}), 64'd0);
      check("idle_gv_fp", 64'(fp_gv), 64'd0);
    end
    slave_ready = 1'b0;

    // single zero-wait read by master 0
    set_master(0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
    read_value  = 32'hDEADBEEF;
    slave_ready = 1'b1;
    settle();
    check("rd_req_cycle_gv", 64'(rr_gv), 64'd0);
    cycle();
    settle();
    check("rd_gv", 64'(rr_gv), 64'd1);
    check("rd_gi", 64'(rr_gi), 64'd0);
    check("rd_addr", 64'(rr_addr), 64'h100);
    check("rd_strobes", 64'({rr_rd, rr_wr}), 64'b10);
    check("rd_ready", 64'(rr_ready), 64'b0001);
    check("rd_data_m0", 64'(rr_rdata[31:0]), 64'hDEADBEEF);
    check("rd_data_others", 64'(|rr_rdata[N*DW-1:DW]), 64'd0);
    check("rd_ready_fp", 64'(fp_ready), 64'b0001);
    check("rd_data_fp", 64'(fp_rdata[31:0]), 64'hDEADBEEF);
    cycle();
    set_master(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    slave_ready = 1'b0;
    settle();
    check("rd_after_gv", 64'(rr_gv), 64'd0);
    check("rd_after_ready", 64'(rr_ready), 64'd0);

    // master 1 write with three wait states, then ready
    set_master(1, 1'b0, 1'b1, 32'h200, 4'b0011, 32'h1234);
    for (int c = 0; c < 4; c++) begin
      cycle();
      slave_ready = (c == 3);
      settle();
      check("wr_gv", 64'(rr_gv), 64'd1);
      check("wr_gi", 64'(rr_gi), 64'd1);
      check("wr_addr", 64'(rr_addr), 64'h200);
      check("wr_strobes", 64'({rr_rd, rr_wr}), 64'b01);
      check("wr_mask", 64'(rr_mask), 64'b0011);
      check("wr_data", 64'(rr_wdata), 64'h1234);
      check("wr_ready", 64'(rr_ready), (c == 3) ? 64'b0010 : 64'd0);
      check("wr_fp_bus", 64'({fp_addr, fp_mask, fp_wr, fp_rd}),
            64'({32'h200, 4'b0011, 1'b1, 1'b0}));
      check("wr_fp_data", 64'(fp_wdata), 64'h1234);
    end
    cycle();
    set_master(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    slave_ready = 1'b0;
    settle();
    check("wr_after_gv", 64'(rr_gv), 64'd0);

    // all four masters requesting, zero-wait slave
    exp_rr = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_master(i, 1'b1, 1'b0, AW'(32'h10 * (i + 1)), 4'h0, 32'h0);
    end
    slave_ready = 1'b1;
    read_value  = 32'hCAFE0001;
    for (int k = 0; k < 5; k++) begin
      oh = 4'(1 << exp_rr[k]);
      cycle();
      settle();
      check("rr_gv", 64'(rr_gv), 64'd1);
      check("rr_gi", 64'(rr_gi), 64'(exp_rr[k]));
      check("rr_ready", 64'(rr_ready), 64'(oh));
      check("rr_addr", 64'(rr_addr), 64'(32'h10 * (exp_rr[k] + 1)));
      check("fp_gi", 64'(fp_gi), 64'd0);
      check("fp_ready", 64'(fp_ready), 64'b0001);
      cycle();
      settle();
      check("rr_gap_gv", 64'(rr_gv), 64'd0);
      check("fp_gap_gv", 64'(fp_gv), 64'd0);
    end
    clear_all();
    slave_ready = 1'b0;

    // abort: master 2 withdraws while granted
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    set_master(2, 1'b1, 1'b0, 32'h300, 4'h0, 32'h0);
    cycle();
    settle();
    check("ab_gi_rr", 64'(rr_gi), 64'd2);
    check("ab_rd_rr", 64'(rr_rd), 64'd1);
    check("ab_gi_fp", 64'(fp_gi), 64'd2);
    set_master(2, 1'b0, 1'b0, 32'h300, 4'h0, 32'h0);
    slave_ready = 1'b1;
    settle();
    check("ab_strobe_rr", 64'({rr_rd, rr_wr}), 64'd0);
    check("ab_ready_rr", 64'(rr_ready), 64'd0);
    check("ab_ready_fp", 64'(fp_ready), 64'd0);
    cycle();
    slave_ready = 1'b0;
    settle();
    check("ab_idle_gv", 64'(rr_gv), 64'd0);

    // masters 0 and 3 tie after the abort: round-robin resumes after 2
    set_master(0, 1'b1, 1'b0, 32'h400, 4'h0, 32'h0);
    set_master(3, 1'b1, 1'b0, 32'h700, 4'h0, 32'h0);
    cycle();
    settle();
    check("tie_gi_rr", 64'(rr_gi), 64'd3);
    check("tie_gi_fp", 64'(fp_gi), 64'd0);
    check("tie_addr_rr", 64'(rr_addr), 64'h700);
    cycle();
    settle();
    check("hold_gi_rr", 64'(rr_gi), 64'd3);
    check("hold_ready_rr", 64'(rr_ready), 64'd0);

    // reset during the grant: dropped, next tie goes to master 0
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    settle();
    check("rst_gv_rr", 64'(rr_gv), 64'd0);
    check("rst_bus_rr", 64'({rr_addr, rr_rd, rr_wr, rr_ready, rr_gi}), 64'd0);
    check("rst_gv_fp", 64'(fp_gv), 64'd0);
    cycle();
    settle();
    check("rst_tie_gv", 64'(rr_gv), 64'd1);
    check("rst_tie_gi_rr", 64'(rr_gi), 64'd0);
    check("rst_tie_addr", 64'(rr_addr), 64'h400);
    clear_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
